// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared types and helpers for the shared-multiplier sequencer.
// Holds the controller state encoding and the latency counter sizing function.
package mul_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter must hold LATENCY-1; never narrower than one bit.
  function automatic int cnt_width(input int lat);
    int w;
    w = $clog2(lat);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mul_share_ctrl_rr_picker.sv
// rr_picker: combinational round-robin pick of the first request
// at or after the pointer, wrapping modulo NREQ.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   id,
  output logic            any
);

  int          idx;
  logic [IW-1:0] sel;

  always_comb begin
    onehot = '0;
    id     = '0;
    any    = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      sel = IW'(idx);
      if (!any && req[sel]) begin
        any         = 1'b1;
        onehot[sel] = 1'b1;
        id          = sel;
      end
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: arbitrates NREQ requesters onto one iterative multiplier core.
// Optional MUL_SHARE_ZERO_BYPASS_EN skips the core when an operand is zero.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NREQ    = 2,
  parameter int LATENCY = 2 * WIDTH + 1,
  parameter int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*WIDTH-1:0] OpA,
  input  logic [NREQ*WIDTH-1:0] OpB,
  output logic [NREQ-1:0]       Gnt,
  output logic [WIDTH-1:0]      MulA,
  output logic [WIDTH-1:0]      MulB,
  output logic                  MulStart,
  input  logic [2*WIDTH-1:0]    MulProduct,
  output logic [2*WIDTH-1:0]    Result,
  output logic                  Done,
  output logic [IW-1:0]         DoneId,
  output logic                  Busy
);

  localparam int CW = cnt_width(LATENCY);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_id;
  logic            pick_any;
  logic [WIDTH-1:0] opa_w;
  logic [WIDTH-1:0] opb_w;
  logic            zbyp;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (Req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .id     (pick_id),
    .any    (pick_any)
  );

  assign opa_w = OpA[pick_id*WIDTH +: WIDTH];
  assign opb_w = OpB[pick_id*WIDTH +: WIDTH];

`ifdef MUL_SHARE_ZERO_BYPASS_EN
  assign zbyp = (opa_w == '0) || (opb_w == '0);
`else
  assign zbyp = 1'b0;
`endif

  assign Busy = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      ptr      <= '0;
      win      <= '0;
      cnt      <= '0;
      Gnt      <= '0;
      MulStart <= 1'b0;
      Done     <= 1'b0;
      MulA     <= '0;
      MulB     <= '0;
      Result   <= '0;
      DoneId   <= '0;
    end else begin
      Gnt      <= '0;
      MulStart <= 1'b0;
      Done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            Gnt  <= pick_oh;
            MulA <= opa_w;
            MulB <= opb_w;
            win  <= pick_id;
            if (zbyp) begin
              Result <= '0;
              state  <= DONE;
            end else begin
              state  <= START;
            end
          end
        end
        START: begin
          MulStart <= 1'b1;
          cnt      <= CW'(LATENCY - 1);
          state    <= RUN;
        end
        RUN: begin
          // Core has no done flag; product is trusted once the count expires.
          if (cnt == '0) begin
            Result <= MulProduct;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          Done   <= 1'b1;
          DoneId <= win;
          ptr    <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: directed scoreboard bench for mul_share_ctrl
// with a behavioural iterative multiplier core.
module tb_mul_share_ctrl;

  localparam int W = 16;
  localparam int N = 2;
  localparam int L = 2 * W + 1;
`ifdef MUL_SHARE_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           Clk = 1'b0;
  logic           Reset;
  logic [N-1:0]   Req;
  logic [N*W-1:0] OpA;
  logic [N*W-1:0] OpB;
  logic [N-1:0]   Gnt;
  logic [W-1:0]   MulA;
  logic [W-1:0]   MulB;
  logic           MulStart;
  logic [2*W-1:0] MulProduct;
  logic [2*W-1:0] Result;
  logic           Done;
  logic [0:0]     DoneId;
  logic           Busy;

  mul_share_ctrl #(
    .WIDTH   (W),
    .NREQ    (N),
    .LATENCY (L)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Req        (Req),
    .OpA        (OpA),
    .OpB        (OpB),
    .Gnt        (Gnt),
    .MulA       (MulA),
    .MulB       (MulB),
    .MulStart   (MulStart),
    .MulProduct (MulProduct),
    .Result     (Result),
    .Done       (Done),
    .DoneId     (DoneId),
    .Busy       (Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Iterative core stand-in: garbage until 2*W cycles after restart.
  logic [2*W-1:0] prod = '0;
  int ccnt = 0;
  always @(posedge Clk) begin
    if (MulStart) begin
      ccnt <= 1;
      prod <= 32'hDEAD_BEEF;
    end else if (ccnt != 0) begin
      if (ccnt == 2 * W - 1) begin
        prod <= {16'h0, MulA} * {16'h0, MulB};
        ccnt <= 0;
      end else begin
        ccnt <= ccnt + 1;
      end
    end
  end
  assign MulProduct = prod;

  typedef struct {
    int             id;
    logic [2*W-1:0] res;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    bit             zero;
  } exp_t;

  exp_t exp_q[$];
  int   errs   = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  int gnt_cyc = 0;
  int nstart  = 0;
  bit moved   = 1'b0;

  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      if (Gnt != '0) begin
        if (exp_q.size() == 0) begin
          chk("gnt_unexpected", 64'(Gnt), 64'h0);
        end else begin
          logic [N-1:0] oh;
          oh = '0;
          oh[exp_q[0].id] = 1'b1;
          chk("gnt_onehot", 64'(Gnt), 64'(oh));
          chk("mula_at_gnt", 64'(MulA), 64'(exp_q[0].a));
          chk("mulb_at_gnt", 64'(MulB), 64'(exp_q[0].b));
          gnt_cyc = cyc;
          nstart  = 0;
          moved   = 1'b0;
        end
      end
      if (MulStart) begin
        nstart++;
        chk("start_cycle", 64'(cyc - gnt_cyc), 64'd1);
      end
      if (Busy && exp_q.size() != 0 &&
          (MulA !== exp_q[0].a || MulB !== exp_q[0].b))
        moved = 1'b1;
      if (Done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 64'(Done), 64'h0);
        end else begin
          exp_t e;
          int   lat;
          int   ns;
          e   = exp_q.pop_front();
          lat = (e.zero && BYP) ? 1 : L + 2;
          ns  = (e.zero && BYP) ? 0 : 1;
          chk("done_id", 64'(DoneId), 64'(e.id));
          chk("result", 64'(Result), 64'(e.res));
          chk("done_latency", 64'(cyc - gnt_cyc), 64'(lat));
          chk("start_count", 64'(nstart), 64'(ns));
          chk("operand_stable", 64'(moved), 64'h0);
          chk("busy_at_done", 64'(Busy), 64'h0);
        end
      end
    end
  end

  task automatic push(input int id, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [2*W-1:0] r);
    exp_t e;
    e.id   = id;
    e.a    = a;
    e.b    = b;
    e.res  = r;
    e.zero = (a == '0) || (b == '0);
    exp_q.push_back(e);
  endtask

  task automatic set_ops(input int id, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    OpA[id*W +: W] = a;
    OpB[id*W +: W] = b;
  endtask

  task automatic wait_gnt(input int id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (Gnt[id]) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_drain();
    int left;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (!Busy && exp_q.size() == 0) break;
    end
    left = exp_q.size();
    chk("drain", 64'(left), 64'h0);
  endtask

  task automatic single(input int id, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] r);
    bit ok;
    push(id, a, b, r);
    set_ops(id, a, b);
    Req[id] = 1'b1;
    wait_gnt(id, ok);
    chk("gnt_timeout", 64'(ok), 64'h1);
    Req[id] = 1'b0;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    bit ok;
    int nd;

    Reset = 1'b0;
    Req   = '0;
    OpA   = '0;
    OpB   = '0;
    repeat (2) @(negedge Clk);
    chk("rst_gnt", 64'(Gnt), 64'h0);
    chk("rst_start", 64'(MulStart), 64'h0);
    chk("rst_done", 64'(Done), 64'h0);
    chk("rst_busy", 64'(Busy), 64'h0);
    chk("rst_result", 64'(Result), 64'h0);
    chk("rst_mula", 64'(MulA), 64'h0);
    Reset = 1'b1;

    single(0, 16'd3, 16'd5, 32'd15);
    single(1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);

    // Both requesting: pointer is back at 0, expect strict alternation.
    push(0, 16'd2, 16'd7, 32'd14);
    push(1, 16'd9, 16'd9, 32'd81);
    push(0, 16'd2, 16'd7, 32'd14);
    push(1, 16'd9, 16'd9, 32'd81);
    set_ops(0, 16'd2, 16'd7);
    set_ops(1, 16'd9, 16'd9);
    Req = 2'b11;
    nd  = 0;
    for (int i = 0; i < 400 && nd < 4; i++) begin
      @(negedge Clk);
      if (Done) nd++;
    end
    Req = 2'b00;
    chk("fair_done_count", 64'(nd), 64'd4);
    wait_drain();

    // Operand changes after grant must not reach the core.
    push(0, 16'd6, 16'd7, 32'd42);
    set_ops(0, 16'd6, 16'd7);
    Req[0] = 1'b1;
    wait_gnt(0, ok);
    chk("hold_gnt_timeout", 64'(ok), 64'h1);
    Req[0] = 1'b0;
    OpA[0 +: W] = 16'hFFFF;
    wait_drain();

    // Pointer is 1 now; reset mid-run must clear it and drop the op.
    push(0, 16'd5, 16'd5, 32'd25);
    set_ops(0, 16'd5, 16'd5);
    Req[0] = 1'b1;
    wait_gnt(0, ok);
    chk("mid_gnt_timeout", 64'(ok), 64'h1);
    Req[0] = 1'b0;
    repeat (12) @(negedge Clk);
    Reset = 1'b0;
    exp_q.delete();
    @(negedge Clk);
    chk("mid_rst_busy", 64'(Busy), 64'h0);
    chk("mid_rst_done", 64'(Done), 64'h0);
    chk("mid_rst_result", 64'(Result), 64'h0);
    chk("mid_rst_mula", 64'(MulA), 64'h0);
    Reset = 1'b1;
    nd = 0;
    repeat (L + 6) begin
      @(negedge Clk);
      if (Done) nd++;
    end
    chk("no_done_after_reset", 64'(nd), 64'h0);

    push(0, 16'd4, 16'd5, 32'd20);
    push(1, 16'd6, 16'd6, 32'd36);
    set_ops(0, 16'd4, 16'd5);
    set_ops(1, 16'd6, 16'd6);
    Req = 2'b11;
    ok  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (Gnt != '0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ptr_reset_gnt", 64'(Gnt), 64'h1);
    Req[0] = 1'b0;
    wait_gnt(1, ok);
    chk("second_gnt_timeout", 64'(ok), 64'h1);
    Req[1] = 1'b0;
    wait_drain();

    single(1, 16'h0000, 16'h1234, 32'h0);

    repeat (3) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Sequencer and round-robin arbiter that shares one iterative shift-add multiplier (2*WIDTH-cycle core) between NREQ requesters, e.g. the MIPS ALU MULT path and a second unit.
- Captures the granted requester's operands, restarts the multiplier core, and counts its fixed latency. It then latches the product and returns it with the requester's id.
- Sits between the requesters and the multiplier core. The core has no start or done signals of its own, so this block provides them.

Parameters:
- WIDTH, 16, operand width. Product is 2*WIDTH.
- NREQ, 2, number of requesters (2..8).
- LATENCY, 2*WIDTH+1, cycles from the MulStart cycle to a valid MulProduct.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-low reset.
- Req  in  NREQ  per-requester request level.
- OpA  in  NREQ*WIDTH  multiplicands, flattened; requester i uses [i*WIDTH +: WIDTH].
- OpB  in  NREQ*WIDTH  multipliers, flattened, same layout.
- Gnt  out  NREQ  one-hot grant, one-cycle pulse.
- MulA  out  WIDTH  registered multiplicand to the core.
- MulB  out  WIDTH  registered multiplier to the core.
- MulStart  out  1  one-cycle restart pulse to the core.
- MulProduct  in  2*WIDTH  core product.
- Result  out  2*WIDTH  latched product.
- Done  out  1  one-cycle valid pulse for Result/DoneId.
- DoneId  out  $clog2(NREQ)  id of the requester that owns Result.
- Busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (Reset==0 at a Clk edge), from any state including mid-operation:
  - state goes to IDLE and the round-robin pointer to 0;
  - Gnt, MulStart, Done, Busy = 0; MulA, MulB, Result, DoneId = 0;
  - the in-flight operation is discarded and no Done is issued.
- IDLE:
  - If Req is nonzero, pick the first set bit at or after the pointer, wrapping modulo NREQ.
  - Register OpA/OpB of the winner into MulA/MulB, pulse its Gnt bit, store the winner id, go to START.
  - If Req is zero, stay in IDLE.
- START: MulStart=1 for exactly one cycle, load the down-counter with LATENCY-1, go to RUN.
- RUN:
  - Decrement the counter each cycle.
  - When the counter is 0, latch MulProduct into Result and go to DONE.
  - MulA/MulB stay stable for the whole operation.
- DONE:
  - Done=1 and DoneId=winner for one cycle.
  - Pointer = winner+1, wrapping NREQ-1 to 0.
  - Go to IDLE.
- Result and DoneId hold their values until the next DONE.
- Latency and throughput:
  - Req sampled in IDLE at cycle t gives Gnt at t+1, MulStart at t+2, Done at t+LATENCY+3.
  - Back-to-back service: one operation per LATENCY+3 cycles.
- Handshake:
  - A requester holds Req and its operands until it sees its Gnt bit. After Gnt it may change them or drop Req.
  - A Req dropped before grant is simply not served.
  - A Req held after Done is treated as a new request.
- Req edges while the state is not IDLE are ignored; arbitration happens only in IDLE.
- Simultaneous requests: the pointer gives fairness. With all requesters asserted, grants rotate 0,1,...,NREQ-1,0.
- Arithmetic is unsigned; this block does no arithmetic beyond the counter. The counter is $clog2(LATENCY) bits wide.

Optional Feature:
- Macro MUL_SHARE_ZERO_BYPASS_EN.
- When defined, in IDLE, if the winner's OpA==0 or OpB==0:
  - Gnt is issued as usual;
  - the state goes directly to DONE with Result=0;
  - MulStart is not pulsed;
  - Done follows Gnt by one cycle, i.e. Req at t gives Done at t+2.
- When undefined, zero operands take the normal full-latency path.

Decomposition:
- Package mul_share_pkg:
  - state enum {IDLE, START, RUN, DONE}, encoded in 2 bits;
  - a function computing the counter width from LATENCY.
- Sub-module rr_picker: combinational.
  - Inputs: Req vector, pointer.
  - Outputs: one-hot winner, winner id, any-request flag.

Test Plan:
- Reset, single request:
  - Reset low for 2 cycles, then Req=01, OpA0=3, OpB0=5.
  - Expect Gnt=01 one cycle later, then one MulStart, then Done with Result=15 and DoneId=0 exactly LATENCY+3 cycles after Req was sampled.
- Fairness with both requesting:
  - Req=11 held continuously, OpA/OpB = (2,7) for requester 0 and (9,9) for requester 1.
  - Expect Dones alternating DoneId 0,1,0,1 with Results 14,81.
- Reset mid-operation:
  - Assert Reset at RUN count 10.
  - Expect Busy=0 and Done=0 on the next cycle, pointer back to 0, no Done ever issued for that operation.
- Operand hold after grant:
  - After Gnt, change OpA0 to 0xFFFF.
  - Expect Result still equal to the originally granted product, with MulA stable throughout RUN.
- Max operands:
  - OpA=OpB=0xFFFF (WIDTH=16).
  - Expect Result=0xFFFE0001.
- Zero operand:
  - OpA=0, OpB=0x1234.
  - With MUL_SHARE_ZERO_BYPASS_EN: Done 2 cycles after Req, Result=0, no MulStart.
  - Without the macro: Done at full latency, Result=0.
